// File: rtl/fft_consts.sv
// Shared constants and types for the radix-2 FFT datapath.
// Holds the write-back FIFO entry layout and write-back FSM state encoding.
package fft_consts;

  // log2 of the transform size; also the memory address width
  localparam int N_LOG2 = 3;

  // issued-but-unwritten butterflies held by the write-back path
  localparam int WB_FIFO_DEPTH = 8;

  // one issued butterfly as captured at read time
  typedef struct packed {
    logic [N_LOG2-1:0] addr_a;
    logic [N_LOG2-1:0] addr_b;
    logic [N_LOG2-1:0] stage;
    logic              bank;
  } wb_entry_t;

  // write-back controller states
  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_ACTIVE = 2'd1,
    WB_DONE   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_addr_fifo.sv
// Synchronous FIFO for issued butterfly descriptors.
// Head word is visible combinationally so a pop can be used in the same cycle.
// full/empty come from the occupancy counter; pointers wrap modulo DEPTH,
// so DEPTH need not be a power of two.
module wb_addr_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 10,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;

  // advance a pointer, wrapping from DEPTH-1 back to zero
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // storage array: written on push, no reset needed since level gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy; reset and clear both empty the FIFO
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == LVL_FULL);
  assign empty = (level_r == {LVL_W{1'b0}});

endmodule

// File: rtl/fft_wb_addr_gen.sv
// Write-back address generator for the in-place radix-2 FFT.
// Captures each issued butterfly, replays its addresses when the BFU result
// arrives, and writes into the bank opposite the one it was read from.
// Tracks writes per stage and signals stage / transform completion.
module fft_wb_addr_gen #(
  parameter int N_LOG2     = fft_consts::N_LOG2,
  parameter int FIFO_DEPTH = fft_consts::WB_FIFO_DEPTH,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              iss_valid,
  input  logic [N_LOG2-1:0] iss_addr_a,
  input  logic [N_LOG2-1:0] iss_addr_b,
  input  logic [N_LOG2-1:0] iss_stage,
  input  logic              iss_bank,
  input  logic              bfu_valid,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic              wr_bank,
  output logic [N_LOG2-1:0] wr_stage,
  output logic              stage_done,
  output logic              xform_done,
  output logic              ovf_err,
  output logic              unf_err,
  output logic [LVL_W-1:0]  fifo_level
);

  import fft_consts::*;

  // same layout as wb_entry_t, but sized by this instance's N_LOG2
  typedef struct packed {
    logic [N_LOG2-1:0] addr_a;
    logic [N_LOG2-1:0] addr_b;
    logic [N_LOG2-1:0] stage;
    logic              bank;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  localparam logic [1:0] ST_IDLE   = WB_IDLE;
  localparam logic [1:0] ST_ACTIVE = WB_ACTIVE;
  localparam logic [1:0] ST_DONE   = WB_DONE;

  // last write index within a stage (N/2-1) and index of the final stage
  localparam logic [N_LOG2-1:0] LAST_WR = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [N_LOG2-1:0] LAST_ST = N_LOG2'(N_LOG2 - 1);

  logic [1:0]        state_r;
  logic [N_LOG2-1:0] wr_cnt_r;
  logic [N_LOG2-1:0] st_cnt_r;
  logic              ovf_err_r;
  logic              unf_err_r;
  logic              stage_done_r;
  logic              xform_done_r;

  logic   active_s;
  logic   enter_s;
  logic   pop_s;
  logic   push_s;
  logic   last_s;
  logic   full_s;
  logic   empty_s;
  entry_t push_entry_s;
  entry_t head_s;

  // control decode: FIFO handshakes and end-of-stage detection
  always_comb begin
    active_s = (state_r == ST_ACTIVE);
    enter_s  = start && !active_s;
    pop_s    = active_s && bfu_valid && !empty_s;
    // a pop in the same cycle frees the slot the push needs
    push_s   = active_s && iss_valid && (!full_s || pop_s);
    last_s   = pop_s && (wr_cnt_r == LAST_WR);
    push_entry_s.addr_a = iss_addr_a;
    push_entry_s.addr_b = iss_addr_b;
    push_entry_s.stage  = iss_stage;
    push_entry_s.bank   = iss_bank;
  end

  wb_addr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (ENTRY_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (enter_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .level (fifo_level),
    .full  (full_s),
    .empty (empty_s)
  );

  // write port: zero-latency from bfu_valid, forced to zero when idle
  always_comb begin
    wr_en = pop_s;
    if (pop_s) begin
      wr_addr_a = head_s.addr_a;
      wr_addr_b = head_s.addr_b;
      wr_stage  = head_s.stage;
      wr_bank   = ~head_s.bank;
    end else begin
      wr_addr_a = {N_LOG2{1'b0}};
      wr_addr_b = {N_LOG2{1'b0}};
      wr_stage  = {N_LOG2{1'b0}};
      wr_bank   = 1'b0;
    end
  end

  // controller FSM: start is only honoured outside ACTIVE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_r <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (last_s && (st_cnt_r == LAST_ST)) state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (start) state_r <= ST_ACTIVE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // write and stage counters; the stage counter holds on the final stage
  always_ff @(posedge clk) begin
    if (rst || enter_s) begin
      wr_cnt_r <= {N_LOG2{1'b0}};
      st_cnt_r <= {N_LOG2{1'b0}};
    end else if (last_s) begin
      wr_cnt_r <= {N_LOG2{1'b0}};
      if (st_cnt_r != LAST_ST) begin
        st_cnt_r <= st_cnt_r + N_LOG2'(1);
      end
    end else if (pop_s) begin
      wr_cnt_r <= wr_cnt_r + N_LOG2'(1);
    end
  end

  // sticky overflow / underflow flags, cleared when a transform begins
  always_ff @(posedge clk) begin
    if (rst || enter_s) begin
      ovf_err_r <= 1'b0;
      unf_err_r <= 1'b0;
    end else if (active_s) begin
      if (iss_valid && full_s && !pop_s) ovf_err_r <= 1'b1;
      if (bfu_valid && empty_s)          unf_err_r <= 1'b1;
    end
  end

  // completion status: one-cycle stage pulse, transform level held until start
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_done_r <= 1'b0;
      xform_done_r <= 1'b0;
    end else begin
      stage_done_r <= last_s;
      if (enter_s) begin
        xform_done_r <= 1'b0;
      end else if (last_s && (st_cnt_r == LAST_ST)) begin
        xform_done_r <= 1'b1;
      end
    end
  end

  assign stage_done = stage_done_r;
  assign xform_done = xform_done_r;
  assign ovf_err    = ovf_err_r;
  assign unf_err    = unf_err_r;

endmodule

// File: tb/tb_fft_wb_addr_gen.sv
// Self-checking bench for fft_wb_addr_gen (N_LOG2=3, FIFO_DEPTH=4).
// Inputs are driven on the falling edge; outputs are compared 1 ns later
// against a queue-based reference model that is advanced once per cycle.
module tb_fft_wb_addr_gen;

  localparam int NL    = 3;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int HALF  = 1 << (NL - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          iss_valid = 1'b0;
  logic [NL-1:0] iss_addr_a = '0;
  logic [NL-1:0] iss_addr_b = '0;
  logic [NL-1:0] iss_stage = '0;
  logic          iss_bank = 1'b0;
  logic          bfu_valid = 1'b0;
  logic          wr_en;
  logic [NL-1:0] wr_addr_a;
  logic [NL-1:0] wr_addr_b;
  logic          wr_bank;
  logic [NL-1:0] wr_stage;
  logic          stage_done;
  logic          xform_done;
  logic          ovf_err;
  logic          unf_err;
  logic [LW-1:0] fifo_level;

  fft_wb_addr_gen #(.N_LOG2(NL), .FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .iss_valid  (iss_valid),
    .iss_addr_a (iss_addr_a),
    .iss_addr_b (iss_addr_b),
    .iss_stage  (iss_stage),
    .iss_bank   (iss_bank),
    .bfu_valid  (bfu_valid),
    .wr_en      (wr_en),
    .wr_addr_a  (wr_addr_a),
    .wr_addr_b  (wr_addr_b),
    .wr_bank    (wr_bank),
    .wr_stage   (wr_stage),
    .stage_done (stage_done),
    .xform_done (xform_done),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // reference model state
  typedef struct {
    logic [NL-1:0] a;
    logic [NL-1:0] b;
    logic [NL-1:0] st;
    logic          bk;
  } ent_t;

  ent_t q[$];
  bit   m_active = 1'b0;
  int   m_writes = 0;
  int   m_stage  = 0;
  bit   m_ovf    = 1'b0;
  bit   m_unf    = 1'b0;
  bit   m_sd     = 1'b0;
  bit   m_xd     = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, compare outputs, then advance the model
  task automatic cycle(input logic r, input logic s, input logic iv,
                       input logic [NL-1:0] a, input logic [NL-1:0] b,
                       input logic [NL-1:0] st, input logic bk, input logic bv);
    bit   pop;
    bit   full;
    bit   end_of_stage;
    ent_t e;
    @(negedge clk);
    rst = r; start = s; iss_valid = iv; iss_addr_a = a; iss_addr_b = b;
    iss_stage = st; iss_bank = bk; bfu_valid = bv;
    #1;
    pop  = m_active && bv && (q.size() > 0);
    full = (q.size() == DEPTH);
    chk("wr_en", wr_en, pop);
    chk("wr_addr_a", wr_addr_a, pop ? q[0].a : 0);
    chk("wr_addr_b", wr_addr_b, pop ? q[0].b : 0);
    chk("wr_stage", wr_stage, pop ? q[0].st : 0);
    chk("wr_bank", wr_bank, pop ? !q[0].bk : 0);
    chk("stage_done", stage_done, m_sd);
    chk("xform_done", xform_done, m_xd);
    chk("ovf_err", ovf_err, m_ovf);
    chk("unf_err", unf_err, m_unf);
    chk("fifo_level", fifo_level, q.size());
    // advance the model across the coming rising edge
    end_of_stage = 1'b0;
    if (r) begin
      q.delete();
      m_active = 0; m_writes = 0; m_stage = 0;
      m_ovf = 0; m_unf = 0; m_xd = 0;
    end else if (!m_active && s) begin
      q.delete();
      m_active = 1; m_writes = 0; m_stage = 0;
      m_ovf = 0; m_unf = 0; m_xd = 0;
    end else if (m_active) begin
      if (bv && q.size() == 0) m_unf = 1;
      if (iv && full && !pop) m_ovf = 1;
      if (pop) begin
        e = q.pop_front();
        m_writes++;
        if (m_writes == HALF) begin
          m_writes = 0;
          end_of_stage = 1'b1;
          if (m_stage == NL - 1) begin
            m_active = 0;
            m_xd = 1;
          end else begin
            m_stage++;
          end
        end
      end
      if (iv && (!full || pop)) begin
        e.a = a; e.b = b; e.st = st; e.bk = bk;
        q.push_back(e);
      end
    end
    m_sd = end_of_stage;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_start();
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // N/2 issues with each BFU result two cycles behind its issue
  task automatic run_stage(input int st, input logic bk, input bit seq);
    logic [NL-1:0] a;
    logic [NL-1:0] b;
    for (int c = 0; c < HALF + 2; c++) begin
      a = seq ? NL'(2 * c) : NL'($urandom_range(0, 7));
      b = seq ? NL'(2 * c + 1) : NL'($urandom_range(0, 7));
      cycle(0, 0, c < HALF, a, b, NL'(st), bk, c >= 2);
    end
  endtask

  initial begin
    // reset state
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // stage 0 with sequential address pairs, then the rest of the transform
    do_start();
    run_stage(0, 1'b0, 1'b1);
    idle(1);
    run_stage(1, 1'b1, 1'b0);
    run_stage(2, 1'b0, 1'b0);
    idle(2);
    // traffic in DONE is ignored; xform_done holds
    cycle(0, 0, 1, 3, 4, 0, 0, 1);
    idle(1);

    // full transform from DONE with random addresses
    do_start();
    run_stage(0, 1'b0, 1'b0);
    run_stage(1, 1'b1, 1'b0);
    run_stage(2, 1'b0, 1'b0);
    idle(2);

    // fill the FIFO, push with simultaneous pop, then overflow
    do_start();
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, NL'(i), NL'(7 - i), 0, 1, 0);
    cycle(0, 0, 1, 5, 6, 0, 1, 1);
    cycle(0, 0, 1, 1, 2, 0, 1, 0);
    idle(1);

    // drain, then underflow; then push and pop together on an empty FIFO
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    cycle(0, 0, 1, 2, 5, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // reset in the middle of stage 1
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    do_start();
    run_stage(0, 1'b0, 1'b0);
    cycle(0, 0, 1, 0, 2, 1, 1, 0);
    cycle(0, 0, 1, 1, 3, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    do_start();
    run_stage(0, 1'b0, 1'b1);
    idle(1);

    // start while ACTIVE is ignored; finish a transform carrying ovf_err
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    do_start();
    cycle(0, 0, 1, 0, 4, 0, 0, 0);
    cycle(0, 0, 1, 1, 5, 0, 0, 0);
    cycle(0, 1, 1, 2, 6, 0, 0, 1);
    cycle(0, 0, 1, 3, 7, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 1, NL'(i), NL'(i + 2), 1, 1, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    run_stage(2, 1'b0, 1'b0);
    idle(1);
    do_start();
    idle(1);

    // randomized traffic, rare starts and resets
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)), NL'($urandom_range(0, 7)),
            NL'($urandom_range(0, 7)), NL'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_wb_addr_gen.md
Name: fft_wb_addr_gen

Overview:
- Write-back address generator for the in-place radix-2 FFT datapath.
- Captures each butterfly's read address pair, stage and bank when the read-side address generator issues it. Holds them in a small FIFO until the BFU presents the result.
- On each BFU result, drives the write enable and addresses into the opposite ping-pong bank.
- Counts completed writes per stage and reports stage and transform completion back to control.

Parameters:
- N_LOG2, fft_consts::N_LOG2, log2 of transform size; address width.
- FIFO_DEPTH, 8, entries of issued-but-unwritten butterflies; must be >= BFU_LAT+1.
- LVL_W, $clog2(FIFO_DEPTH+1), width of fifo_level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin transform; clears counters, FIFO, errors
- iss_valid  in  1  butterfly issued this cycle
- iss_addr_a  in  N_LOG2  read address A of issued butterfly
- iss_addr_b  in  N_LOG2  read address B of issued butterfly
- iss_stage  in  N_LOG2  stage of issued butterfly
- iss_bank  in  1  read bank of issued butterfly
- bfu_valid  in  1  BFU output pair valid this cycle
- wr_en  out  1  write both result words this cycle
- wr_addr_a  out  N_LOG2  write address for result A
- wr_addr_b  out  N_LOG2  write address for result B
- wr_bank  out  1  bank written (= ~captured iss_bank)
- wr_stage  out  N_LOG2  stage of current write
- stage_done  out  1  one-cycle pulse: all N/2 writes of a stage committed
- xform_done  out  1  level: all N_LOG2 stages committed
- ovf_err  out  1  sticky: issue dropped on full FIFO
- unf_err  out  1  sticky: bfu_valid with empty FIFO
- fifo_level  out  LVL_W  current FIFO occupancy

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; FIFO empty; write and stage counters 0; all outputs 0, including fifo_level.
- Reset mid-operation discards all FIFO contents and progress.
- FSM states:
  - IDLE: start -> ACTIVE.
  - ACTIVE: final stage_done -> DONE.
  - DONE: start -> ACTIVE.
  - start is ignored in ACTIVE.
  - Entering ACTIVE clears the FIFO, wr_cnt, st_cnt, ovf_err and unf_err.
- Push: iss_valid in ACTIVE with (!full or pop this cycle) pushes {addr_a, addr_b, stage, bank}. iss_valid in IDLE/DONE is ignored.
- Pop: pop = ACTIVE && bfu_valid && !empty.
  - wr_en = pop, combinational; zero-cycle latency from bfu_valid.
  - wr_addr_a/b, wr_stage and ~bank are taken from the FIFO head. They read 0 when wr_en=0.
- Simultaneous push and pop when full: both accepted; level unchanged.
- Simultaneous push and pop when empty: the pop sees empty, so unf_err is set and the push still occurs (no bypass).
- Overflow: iss_valid && full && !pop -> entry dropped, ovf_err=1 (sticky until start/rst).
- Underflow: bfu_valid && empty in ACTIVE -> no write, unf_err=1 (sticky).
- Pointers are modulo FIFO_DEPTH with wrap; full/empty are derived from the occupancy counter.
- wr_cnt counts pops within a stage. On the pop with wr_cnt == N/2-1:
  - wr_cnt <= 0; stage_done is registered high on the next cycle for exactly 1 cycle.
  - If st_cnt != N_LOG2-1: st_cnt++.
  - Else: go to DONE; xform_done is registered high with that stage_done and held until start/rst.
- Writes in DONE are impossible (pop requires ACTIVE); a bfu_valid in DONE is ignored.
- All arithmetic is unsigned; counters are N_LOG2 wide and wrap naturally (N/2-1 fits).

Decomposition:
- fft_consts gains:
  - wb_entry_t packed struct {addr_a, addr_b, stage, bank}.
  - WB_FIFO_DEPTH constant.
  - wb_state_t enum {WB_IDLE, WB_ACTIVE, WB_DONE}.
- One natural sub-module: wb_addr_fifo, a synchronous FIFO of wb_entry_t with level, full and empty outputs.
- The top module holds the FSM, counters and error flags.

Test Plan (N_LOG2=3, BFU_LAT=2, FIFO_DEPTH=4):
1. start; issue (0,1),(2,3),(4,5),(6,7) with iss_bank=0, stage 0; bfu_valid 2 cycles after each issue -> 4 writes with identical addresses, wr_bank=1, wr_stage=0; stage_done single pulse the cycle after the 4th write.
2. Full 3-stage transform, iss_bank 0/1/0 -> 12 writes with wr_bank 1/0/1; 3 stage_done pulses; xform_done rises with the 3rd pulse and holds until next start.
3. Four issues, no bfu_valid -> fifo_level=4:
   - 5th issue with simultaneous bfu_valid -> accepted, level stays 4, ovf_err=0.
   - 5th issue alone -> ovf_err=1, level 4, entry dropped.
4. bfu_valid while FIFO empty -> wr_en=0, unf_err=1, wr_cnt unchanged; unf_err persists until next start.
5. rst asserted after 2 writes of stage 1 -> all outputs 0, fifo_level=0; then start and 4 clean butterflies -> stage_done after 4th write, wr_stage=0.
6. start pulsed while ACTIVE mid-stage -> ignored, counts continue; start in DONE with ovf_err=1 -> errors cleared, xform_done=0, returns to ACTIVE.
